// File: rtl/irom_responder_pkg.sv
// Shared definitions for the instruction-ROM responder: default geometry,
// the NOP word returned for idle/out-of-range fetches, and the loader FSM states.
// Imported by irom_responder and irom_ram.
package irom_responder_pkg;

  localparam int unsigned IROM_DEPTH = 4096;
  localparam int unsigned IROM_AW    = 12;

  // addi x0, x0, 0
  localparam logic [31:0] IROM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } irom_state_e;

endpackage

// File: rtl/irom_ram.sv
// Single-port DEPTH x 32 instruction array with synchronous write and synchronous read.
// Ports: clk; we_i/addr_i/wdata_i write port sharing addr_i with the read; rdata_o is
// the registered read of addr_i. No reset, so the array and read register map onto block RAM.
module irom_ram
  import irom_responder_pkg::*;
#(
  parameter int unsigned DEPTH = IROM_DEPTH,
  parameter int unsigned AW    = IROM_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/irom_responder.sv
// Instruction-memory responder for the rv32 fetch port, with a byte-serial boot loader
// that fills the array while holding the core in reset and releases it once loading ends.
// Ports: clk, rst_n (async, active-low); pc_i -> inst_o (1-cycle registered fetch);
//   ld_start_i/ld_words_i start a load; ld_byte_i/ld_valid_i/ld_ready_o byte stream;
//   ld_done_o and core_rst_n_o report RUN; misalign_err_o sticky misaligned-fetch flag.
// Optional: define IROM_MISALIGN_CHK_EN to turn misaligned fetches into NOP and flag them;
//   otherwise pc_i[1:0] is ignored and misalign_err_o is tied low.
module irom_responder
  import irom_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = IROM_DEPTH,
  parameter int unsigned AW        = IROM_AW,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic [AW:0] ld_words_i,
  input  logic [7:0]  ld_byte_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        core_rst_n_o,
  output logic        misalign_err_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  irom_state_e state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic [AW:0] len_q, len_d;
  logic [23:0] wbuf_q, wbuf_d;
  logic        done_q, done_d;
  logic        rd_vld_q, rd_vld_d;

  logic          start_ok;
  logic          accept;
  logic          last_byte;
  logic          last_word;
  logic [AW:0]   len_clamped;
  logic [32:0]   off;
  logic          in_range;
  logic [AW-1:0] fetch_idx;
  logic          misalign_hit;
  logic          unused_off;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // ld_start_i is only honoured outside LOAD
  assign start_ok    = ld_start_i && (state_q != ST_LOAD);
  assign accept      = (state_q == ST_LOAD) && ld_valid_i;
  assign last_byte   = accept && (byte_cnt_q == 2'd3);
  assign last_word   = last_byte && (word_cnt_q == (len_q - ONE_W));
  assign len_clamped = (ld_words_i > DEPTH_W) ? DEPTH_W : ld_words_i;

  // Extra MSB catches pc_i < BASE_ADDR as a borrow; any bit above the
  // word index means the fetch is past the end of the array.
  assign off        = {1'b0, pc_i} - {1'b0, BASE_ADDR};
  assign fetch_idx  = off[AW+1:2];
  assign in_range   = !off[32] && (off[31:AW+2] == '0);
  assign unused_off = ^off[1:0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ld_start_i) begin
          state_d = (ld_words_i != '0) ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (last_word) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ld_ready_o = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = fetch_idx;
    ram_wdata  = {ld_byte_i, wbuf_q};
    if (state_q == ST_LOAD) begin
      ld_ready_o = 1'b1;
      ram_we     = last_byte;
      ram_addr   = word_cnt_q[AW-1:0];
    end
  end

  // ---------------- byte packer and counters ----------------
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    wbuf_d     = wbuf_q;
    if (start_ok) begin
      byte_cnt_d = 2'd0;
      word_cnt_d = '0;
      len_d      = len_clamped;
    end else if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0: wbuf_d[7:0]   = ld_byte_i;
        2'd1: wbuf_d[15:8]  = ld_byte_i;
        2'd2: wbuf_d[23:16] = ld_byte_i;
        // byte 3 goes straight to the array alongside wbuf_q
        default: word_cnt_d = word_cnt_q + ONE_W;
      endcase
    end
  end

  // Released one cycle after RUN is entered; a start in RUN pulls it low again.
  assign done_d   = (state_q == ST_RUN) && !ld_start_i;
  assign rd_vld_d = (state_q == ST_RUN) && in_range && !misalign_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      len_q      <= '0;
      wbuf_q     <= '0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      wbuf_q     <= wbuf_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  assign ld_done_o    = done_q;
  assign core_rst_n_o = done_q;

`ifdef IROM_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign misalign_hit = (pc_i[1:0] != 2'b00);

  always_comb begin
    misalign_d = misalign_q;
    if (start_ok) begin
      misalign_d = 1'b0;
    end else if ((state_q == ST_RUN) && misalign_hit) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err_o = misalign_q;
`else
  assign misalign_hit   = 1'b0;
  assign misalign_err_o = 1'b0;
`endif

  irom_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM output register is the fetch pipeline stage; rd_vld_q was registered
  // alongside it and substitutes NOP for idle, out-of-range or misaligned fetches.
  assign inst_o = rd_vld_q ? ram_rdata : IROM_NOP;

endmodule

// File: tb/tb_irom_responder.sv
module tb_irom_responder;

  localparam int          DEPTH = 4096;
  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IROM_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic [31:0] inst_o;
  logic        ld_start_i;
  logic [AW:0] ld_words_i;
  logic [7:0]  ld_byte_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        core_rst_n_o;
  logic        misalign_err_o;

  irom_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_i           (pc_i),
    .inst_o         (inst_o),
    .ld_start_i     (ld_start_i),
    .ld_words_i     (ld_words_i),
    .ld_byte_i      (ld_byte_i),
    .ld_valid_i     (ld_valid_i),
    .ld_ready_o     (ld_ready_o),
    .ld_done_o      (ld_done_o),
    .core_rst_n_o   (core_rst_n_o),
    .misalign_err_o (misalign_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: array contents as the loader should have written them.
  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  int          known_q[$];
  logic [31:0] load_data [DEPTH];
  bit          exp_err;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fvec_t;
  fvec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    longint off;
    off = longint'({32'd0, pc}) - longint'({32'd0, BASE});
    if (off < 0 || (off >> 2) >= DEPTH) return NOP;
    if (MIS_EN && pc[1:0] != 2'b00) return NOP;
    return model_mem[int'(off >> 2)];
  endfunction

  task automatic mark_known(input int w);
    if (!known[w]) begin
      known[w] = 1'b1;
      known_q.push_back(w);
    end
  endtask

  // Start a load of n_req words from load_data[], throttling ld_valid_i with
  // probability thr percent. glitch fires an ld_start_i while loading.
  task automatic do_load(input int n_req, input int thr, input bit glitch);
    int n_eff;
    int rdy_bad;
    n_eff = (n_req > DEPTH) ? DEPTH : n_req;
    ld_words_i = (AW+1)'(n_req);
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    exp_err = 1'b0;
    check1("start_core_rst", core_rst_n_o, 1'b0);
    check1("start_ld_done", ld_done_o, 1'b0);
    check1("start_err_clr", misalign_err_o, 1'b0);
    if (n_eff == 0) begin
      check1("zero_no_ready", ld_ready_o, 1'b0);
      tick();
      check1("zero_no_ready2", ld_ready_o, 1'b0);
      check1("zero_core_run", core_rst_n_o, 1'b1);
      check1("zero_ld_done", ld_done_o, 1'b1);
      return;
    end
    check1("load_ready", ld_ready_o, 1'b1);
    rdy_bad = 0;
    for (int w = 0; w < n_eff; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (glitch && w == 1 && b == 0) begin
          ld_words_i = (AW+1)'(1);
          ld_start_i = 1'b1;
          tick();
          ld_start_i = 1'b0;
          if (!ld_ready_o) rdy_bad++;
        end
        while ($urandom_range(0, 99) < thr) begin
          ld_byte_i = 8'($urandom);
          tick();
          if (!ld_ready_o) rdy_bad++;
        end
        ld_byte_i  = load_data[w][8*b +: 8];
        ld_valid_i = 1'b1;
        tick();
        ld_valid_i = 1'b0;
        if (!(w == n_eff - 1 && b == 3) && !ld_ready_o) rdy_bad++;
      end
      model_mem[w] = load_data[w];
      mark_known(w);
    end
    check32("ready_held", rdy_bad, 0);
    check1("ready_drop", ld_ready_o, 1'b0);
    check1("core_held_at_entry", core_rst_n_o, 1'b0);
    tick();
    check1("core_release", core_rst_n_o, 1'b1);
    check1("ld_done", ld_done_o, 1'b1);
  endtask

  task automatic rand_fetch(input int n);
    logic [31:0] pc;
    int k;
    int idx;
    for (int i = 0; i < n; i++) begin
      k   = $urandom_range(0, 9);
      idx = known_q[$urandom_range(0, known_q.size() - 1)];
      if (k == 0)      pc = 32'(DEPTH * 4 + 4 * $urandom_range(0, 255));
      else if (k == 1) pc = $urandom | 32'h8000_0000;
      else if (k == 2) pc = 32'(idx * 4) + 32'($urandom_range(1, 3));
      else             pc = 32'(idx * 4);
      pc   = pc + BASE;
      pc_i = pc;
      tick();
      if (MIS_EN && pc[1:0] != 2'b00) exp_err = 1'b1;
      check32("rand_fetch", inst_o, exp_inst(pc));
      check1("rand_err", misalign_err_o, exp_err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    rst_n      = 1'b1;
    pc_i       = 32'h0;
    ld_start_i = 1'b0;
    ld_words_i = '0;
    ld_byte_i  = 8'h0;
    ld_valid_i = 1'b0;
    exp_err    = 1'b0;

    // 1: reset values
    #1 rst_n = 1'b0;
    tick();
    tick();
    check32("rst_inst", inst_o, NOP);
    check1("rst_core_rst", core_rst_n_o, 1'b0);
    check1("rst_ready", ld_ready_o, 1'b0);
    check1("rst_done", ld_done_o, 1'b0);
    check1("rst_err", misalign_err_o, 1'b0);
    rst_n = 1'b1;
    tick();
    check32("idle_inst", inst_o, NOP);

    // 2: two-word load, bytes 93 00 10 00 13 01 20 00, throttled
    load_data[0] = 32'h0010_0093;
    load_data[1] = 32'h0020_0113;
    do_load(2, 40, 1'b0);

    // 3: table-driven fetches
    tbl[0] = '{"pc0",      32'h0,               32'h0010_0093, 1'b0};
    tbl[1] = '{"pc4",      32'h4,               32'h0020_0113, 1'b0};
    tbl[2] = '{"pc_end",   32'(DEPTH * 4),      NOP,           1'b0};
    tbl[3] = '{"pc_top",   32'hFFFF_FFFC,       NOP,           1'b0};
    tbl[4] = '{"pc4b",     32'h4,               32'h0020_0113, 1'b0};
    tbl[5] = '{"pc2_mis",  32'h2,               MIS_EN ? NOP : 32'h0010_0093, MIS_EN};
    tbl[6] = '{"pc0_stky", 32'h0,               32'h0010_0093, MIS_EN};
    tbl[7] = '{"pc6_mis",  32'h6,               MIS_EN ? NOP : 32'h0020_0113, MIS_EN};
    for (int i = 0; i < 8; i++) begin
      pc_i = tbl[i].pc;
      tick();
      check32({"tbl_inst_", tbl[i].name}, inst_o, tbl[i].inst);
      check1({"tbl_err_", tbl[i].name}, misalign_err_o, tbl[i].err);
    end
    exp_err = MIS_EN;

    // latency: output holds until the next edge, then follows the new pc
    pc_i = 32'h0;
    tick();
    pc_i = 32'h4;
    #2;
    check32("lat_hold", inst_o, 32'h0010_0093);
    tick();
    check32("lat_next", inst_o, 32'h0020_0113);

    // 4: async reset mid-cycle from RUN, no clock edge needed
    pc_i = 32'h0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check32("async_inst", inst_o, NOP);
    check1("async_core_rst", core_rst_n_o, 1'b0);
    check1("async_done", ld_done_o, 1'b0);
    check1("async_err", misalign_err_o, 1'b0);
    tick();
    rst_n   = 1'b1;
    exp_err = 1'b0;
    // zero-length load from IDLE: straight to RUN without a ready pulse
    do_load(0, 0, 1'b0);
    pc_i = 32'h0;
    tick();
    check32("retained_w0", inst_o, model_mem[0]);

    // 5: random reload from RUN with an ignored start mid-load
    for (int w = 0; w < DEPTH; w++) load_data[w] = $urandom;
    do_load($urandom_range(3, 24), 30, 1'b1);
    rand_fetch(300);

    // reset after five bytes of a three-word load: word 0 kept, word 1 untouched
    for (int w = 0; w < 3; w++) load_data[w] = $urandom;
    ld_words_i = (AW+1)'(3);
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      ld_byte_i  = (b < 4) ? load_data[0][8*b +: 8] : load_data[1][7:0];
      ld_valid_i = 1'b1;
      tick();
      ld_valid_i = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    check1("midload_ready", ld_ready_o, 1'b0);
    check1("midload_core", core_rst_n_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check1("midload_idle_ready", ld_ready_o, 1'b0);
    model_mem[0] = load_data[0];
    exp_err = 1'b0;
    do_load(0, 0, 1'b0);
    pc_i = 32'h0;
    tick();
    check32("midload_w0", inst_o, load_data[0]);
    pc_i = 32'h4;
    tick();
    check32("midload_w1", inst_o, model_mem[1]);
    rand_fetch(60);

    // DEPTH+1 words requested: exactly DEPTH accepted, later bytes ignored
    for (int w = 0; w < DEPTH; w++) load_data[w] = $urandom;
    do_load(DEPTH + 1, 0, 1'b0);
    ld_byte_i  = 8'hFF;
    ld_valid_i = 1'b1;
    tick();
    ld_valid_i = 1'b0;
    check1("full_ready_low", ld_ready_o, 1'b0);
    check1("full_done", ld_done_o, 1'b1);
    mism = 0;
    for (int w = 0; w < DEPTH; w++) begin
      pc_i = BASE + 32'(w * 4);
      tick();
      if (inst_o !== model_mem[w]) begin
        if (mism == 0) $display("readback word %0d: got %h expected %h", w, inst_o, model_mem[w]);
        mism++;
      end
    end
    check32("full_readback_mismatches", mism, 0);
    pc_i = BASE + 32'(DEPTH * 4);
    tick();
    check32("full_past_end", inst_o, NOP);
    rand_fetch(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
